hilo_muldiv_ctrl: RTL and testbench

- Iterative multiply/divide sequencer owning the HI/LO register pair.
- Executes the ALU multiply/divide control codes (1100–1111) over multiple cycles instead of in one combinational pass.
- Sits beside the ALU in the EX stage and raises busy so the pipeline control can stall later HI/LO consumers.
- Also services direct HI/LO writes (move-to-HI/LO).

---
 rtl/mdu_pkg.sv | 25 ++
 rtl/hilo_muldiv_ctrl_if.sv | 27 ++
 rtl/mdu_iter_core.sv | 36 +++
 rtl/hilo_muldiv_ctrl.sv | 162 ++++++++++++++++
 tb/tb_hilo_muldiv_ctrl.sv | 157 +++++++++++++++
 5 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer.
// The op codes are also used by the ALU control decoder.
package mdu_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int CNT_W_DEF = 6;

  localparam logic [3:0] OP_MULU = 4'b1100;
  localparam logic [3:0] OP_DIVU = 4'b1101;
  localparam logic [3:0] OP_MUL  = 4'b1110;
  localparam logic [3:0] OP_DIV  = 4'b1111;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RUN  = 3'd1,
    ST_FIX  = 3'd2,
    ST_DZ   = 3'd3,
    ST_DONE = 3'd4
  } mdu_state_t;

  function automatic logic is_mdu_op(input logic [3:0] op);
    return (op == OP_MULU) || (op == OP_DIVU) || (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/hilo_muldiv_ctrl_if.sv
// Request/result bundle between the EX-stage control and the HI/LO sequencer.
interface hilo_muldiv_ctrl_if #(
  parameter int WIDTH = mdu_pkg::WIDTH_DEF
);
  logic             start;
  logic [3:0]       op;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             mthi;
  logic             mtlo;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             dz;

  modport master (
    output start, op, in1, in2, mthi, mtlo, wdata,
    input  hi, lo, busy, done, dz
  );

  modport slave (
    input  start, op, in1, in2, mthi, mtlo, wdata,
    output hi, lo, busy, done, dz
  );
endinterface

// File: rtl/mdu_iter_core.sv
// One iteration of the multiply (shift-add, LSB first) or restoring divide
// (shift-subtract, MSB first) over a 2*WIDTH accumulator.
module mdu_iter_core #(
  parameter int WIDTH = 32
) (
  input  logic               is_div,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   opd,
  output logic [2*WIDTH-1:0] acc_next
);

  logic [WIDTH:0] sum_s;
  logic [WIDTH:0] partial_s;
  logic [WIDTH:0] diff_s;

  // Next accumulator; in divide mode diff_s[WIDTH] is the borrow of the trial subtract
  always_comb begin
    sum_s     = '0;
    partial_s = '0;
    diff_s    = '0;
    acc_next  = '0;
    if (is_div) begin
      partial_s = acc[2*WIDTH-1:WIDTH-1];
      diff_s    = partial_s - {1'b0, opd};
      if (!diff_s[WIDTH]) begin
        acc_next = {diff_s[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      end else begin
        acc_next = {partial_s[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end
    end else begin
      sum_s    = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opd} : {(WIDTH+1){1'b0}});
      acc_next = {sum_s, acc[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// Iterative multiply/divide sequencer owning HI/LO; operands are made
// unsigned on entry and signs are reapplied in FIX.
module hilo_muldiv_ctrl
  import mdu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  hilo_muldiv_ctrl_if.slave   bus
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  mdu_state_t         state_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [2*WIDTH-1:0] acc_r;
  logic [WIDTH-1:0]   opd_r;
  logic               is_div_r;
  logic               neg_res_r;
  logic               neg_rem_r;
  logic [WIDTH-1:0]   hi_r;
  logic [WIDTH-1:0]   lo_r;
  logic               busy_r;
  logic               done_r;
  logic               dz_r;

  logic [2*WIDTH-1:0] acc_next_s;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   abs1_s;
  logic [WIDTH-1:0]   abs2_s;
  logic [WIDTH-1:0]   fix_hi_s;
  logic [WIDTH-1:0]   fix_lo_s;
  logic               accept_s;

  mdu_iter_core #(.WIDTH(WIDTH)) u_core (
    .is_div   (is_div_r),
    .acc      (acc_r),
    .opd      (opd_r),
    .acc_next (acc_next_s)
  );

  // Operand magnitudes for signed ops; -2^(WIDTH-1) maps onto itself, which is its correct unsigned magnitude
  always_comb begin
    accept_s = bus.start && is_mdu_op(bus.op);
    abs1_s   = bus.in1;
    abs2_s   = bus.in2;
    if (bus.op[1] && bus.in1[WIDTH-1]) begin
      abs1_s = -bus.in1;
    end else begin
      abs1_s = bus.in1;
    end
    if (bus.op[1] && bus.in2[WIDTH-1]) begin
      abs2_s = -bus.in2;
    end else begin
      abs2_s = bus.in2;
    end
  end

  // Sign fix-up of the unsigned result held in the accumulator
  always_comb begin
    prod_s   = acc_r;
    fix_hi_s = acc_r[2*WIDTH-1:WIDTH];
    fix_lo_s = acc_r[WIDTH-1:0];
    if (is_div_r) begin
      if (neg_res_r) begin
        fix_lo_s = -acc_r[WIDTH-1:0];
      end else begin
        fix_lo_s = acc_r[WIDTH-1:0];
      end
      if (neg_rem_r) begin
        fix_hi_s = -acc_r[2*WIDTH-1:WIDTH];
      end else begin
        fix_hi_s = acc_r[2*WIDTH-1:WIDTH];
      end
    end else begin
      if (neg_res_r) begin
        prod_s = -acc_r;
      end else begin
        prod_s = acc_r;
      end
      fix_hi_s = prod_s[2*WIDTH-1:WIDTH];
      fix_lo_s = prod_s[WIDTH-1:0];
    end
  end

  // Sequencer FSM, iteration counter and HI/LO ownership
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      cnt_r     <= '0;
      acc_r     <= '0;
      opd_r     <= '0;
      is_div_r  <= 1'b0;
      neg_res_r <= 1'b0;
      neg_rem_r <= 1'b0;
      hi_r      <= '0;
      lo_r      <= '0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      dz_r      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            acc_r     <= {{WIDTH{1'b0}}, abs1_s};
            opd_r     <= abs2_s;
            is_div_r  <= bus.op[0];
            neg_res_r <= bus.op[1] & (bus.in1[WIDTH-1] ^ bus.in2[WIDTH-1]);
            neg_rem_r <= bus.op[1] & bus.in1[WIDTH-1];
            dz_r      <= 1'b0;
            busy_r    <= 1'b1;
            cnt_r     <= '0;
            state_r   <= (bus.op[0] && (bus.in2 == '0)) ? ST_DZ : ST_RUN;
          end else begin
            if (bus.mthi) hi_r <= bus.wdata;
            if (bus.mtlo) lo_r <= bus.wdata;
          end
        end
        ST_RUN: begin
          acc_r <= acc_next_s;
          cnt_r <= cnt_r + CNT_W'(1);
          if (cnt_r == LAST_CNT) state_r <= ST_FIX;
        end
        ST_FIX: begin
          hi_r    <= fix_hi_s;
          lo_r    <= fix_lo_s;
          busy_r  <= 1'b0;
          done_r  <= 1'b1;
          state_r <= ST_DONE;
        end
        ST_DZ: begin
          hi_r    <= '0;
          lo_r    <= '0;
          dz_r    <= 1'b1;
          busy_r  <= 1'b0;
          done_r  <= 1'b1;
          state_r <= ST_DONE;
        end
        ST_DONE: begin
          done_r  <= 1'b0;
          if (bus.mthi) hi_r <= bus.wdata;
          if (bus.mtlo) lo_r <= bus.wdata;
          state_r <= ST_IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.hi   = hi_r;
  assign bus.lo   = lo_r;
  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.dz   = dz_r;

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Directed bench for hilo_muldiv_ctrl: latency, results, collisions, reset abort.
module tb_hilo_muldiv_ctrl;
  import mdu_pkg::*;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;
  int   lat;
  int   bcnt;
  int   pulses;

  hilo_muldiv_ctrl_if #(.WIDTH(32)) bus ();

  hilo_muldiv_ctrl #(.WIDTH(32), .CNT_W(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issues one op and waits (bounded) for done; returns to the caller in the DONE cycle
  task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                        input bit inject, output int lat_o, output int bcnt_o);
    @(negedge clk);
    bus.start = 1'b1; bus.op = o; bus.in1 = a; bus.in2 = b;
    @(negedge clk);
    bus.start = 1'b0; bus.in1 = ~a; bus.in2 = ~b;
    lat_o = 0; bcnt_o = 0;
    check_eq("dz_clear_on_start", {63'd0, bus.dz}, 64'd0);
    for (int n = 1; n <= 40; n++) begin
      if (bus.done) begin
        lat_o = n;
        break;
      end
      if (bus.busy) bcnt_o++;
      if (inject && n == 5) begin
        bus.start = 1'b1; bus.op = OP_DIVU; bus.in1 = 32'd100; bus.in2 = 32'd7;
        bus.mtlo = 1'b1; bus.wdata = 32'h0000_DEAD;
      end else if (inject && n == 6) begin
        bus.start = 1'b0; bus.mtlo = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    reset = 1'b1;
    bus.start = 1'b0; bus.op = 4'b0000; bus.in1 = 32'd0; bus.in2 = 32'd0;
    bus.mthi = 1'b0; bus.mtlo = 1'b0; bus.wdata = 32'd0;
    repeat (2) @(negedge clk);
    check_eq("rst_hi", {32'd0, bus.hi}, 64'd0);
    check_eq("rst_lo", {32'd0, bus.lo}, 64'd0);
    check_eq("rst_busy", {63'd0, bus.busy}, 64'd0);
    check_eq("rst_done", {63'd0, bus.done}, 64'd0);
    check_eq("rst_dz", {63'd0, bus.dz}, 64'd0);
    reset = 1'b0;

    // mthi in IDLE
    bus.mthi = 1'b1; bus.wdata = 32'h0000_1234;
    @(negedge clk);
    bus.mthi = 1'b0;
    check_eq("mthi_hi", {32'd0, bus.hi}, 64'h1234);
    check_eq("mthi_lo", {32'd0, bus.lo}, 64'd0);

    // start with a non-MDU op is ignored
    bus.start = 1'b1; bus.op = 4'b0110;
    @(negedge clk);
    bus.start = 1'b0;
    check_eq("bad_op_busy", {63'd0, bus.busy}, 64'd0);

    run_op(OP_MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, lat, bcnt);
    check_eq("mulu_lat", 64'(lat), 64'd34);
    check_eq("mulu_busy_cycles", 64'(bcnt), 64'd33);
    check_eq("mulu_busy_in_done", {63'd0, bus.busy}, 64'd0);
    check_eq("mulu_hi", {32'd0, bus.hi}, 64'hFFFF_FFFE);
    check_eq("mulu_lo", {32'd0, bus.lo}, 64'h0000_0001);
    @(negedge clk);
    check_eq("done_one_cycle", {63'd0, bus.done}, 64'd0);

    run_op(OP_MUL, 32'hFFFF_FFFD, 32'd7, 1'b0, lat, bcnt);
    check_eq("mul_lat", 64'(lat), 64'd34);
    check_eq("mul_hi", {32'd0, bus.hi}, 64'hFFFF_FFFF);
    check_eq("mul_lo", {32'd0, bus.lo}, 64'hFFFF_FFEB);
    check_eq("mul_dz", {63'd0, bus.dz}, 64'd0);
    // start ignored in DONE; mthi+mtlo together both honoured
    bus.start = 1'b1; bus.op = OP_MULU; bus.mthi = 1'b1; bus.mtlo = 1'b1; bus.wdata = 32'h0000_55AA;
    @(negedge clk);
    bus.start = 1'b0; bus.mthi = 1'b0; bus.mtlo = 1'b0;
    check_eq("done_start_busy", {63'd0, bus.busy}, 64'd0);
    check_eq("mthilo_hi", {32'd0, bus.hi}, 64'h55AA);
    check_eq("mthilo_lo", {32'd0, bus.lo}, 64'h55AA);

    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, lat, bcnt);
    check_eq("div_lat", 64'(lat), 64'd34);
    check_eq("div_lo", {32'd0, bus.lo}, 64'hFFFF_FFFD);
    check_eq("div_hi", {32'd0, bus.hi}, 64'hFFFF_FFFF);

    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, lat, bcnt);
    check_eq("divmin_lo", {32'd0, bus.lo}, 64'h8000_0000);
    check_eq("divmin_hi", {32'd0, bus.hi}, 64'd0);
    check_eq("divmin_dz", {63'd0, bus.dz}, 64'd0);

    run_op(OP_DIVU, 32'd5, 32'd0, 1'b0, lat, bcnt);
    check_eq("dz_lat", 64'(lat), 64'd2);
    check_eq("dz_busy_cycles", 64'(bcnt), 64'd1);
    check_eq("dz_hi", {32'd0, bus.hi}, 64'd0);
    check_eq("dz_lo", {32'd0, bus.lo}, 64'd0);
    check_eq("dz_flag", {63'd0, bus.dz}, 64'd1);
    @(negedge clk);
    check_eq("dz_held", {63'd0, bus.dz}, 64'd1);

    // start + mtlo during RUN are both ignored; the next accepted start clears dz
    run_op(OP_MULU, 32'd3, 32'd4, 1'b1, lat, bcnt);
    check_eq("coll_lat", 64'(lat), 64'd34);
    check_eq("coll_lo", {32'd0, bus.lo}, 64'd12);
    check_eq("coll_hi", {32'd0, bus.hi}, 64'd0);
    check_eq("coll_dz", {63'd0, bus.dz}, 64'd0);
    @(negedge clk);
    check_eq("coll_no_queue", {63'd0, bus.busy}, 64'd0);

    // reset at cycle 10 of a divide
    bus.start = 1'b1; bus.op = OP_DIVU; bus.in1 = 32'd100; bus.in2 = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    check_eq("pre_rst_busy", {63'd0, bus.busy}, 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_eq("abort_busy", {63'd0, bus.busy}, 64'd0);
    check_eq("abort_done", {63'd0, bus.done}, 64'd0);
    check_eq("abort_hi", {32'd0, bus.hi}, 64'd0);
    check_eq("abort_lo", {32'd0, bus.lo}, 64'd0);
    pulses = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (bus.done) pulses++;
    end
    check_eq("abort_no_done", 64'(pulses), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
